// File: rtl/iic_reg_master.sv
// Single-master SMBus/I2C initiator for one-byte register writes and reads.
// SCL/SDA are driven through active-low open-drain enables; target clock stretching is honoured.
module iic_reg_master #(
    parameter int unsigned QTR_DIV = 63
) (
    input  logic       iClk,
    input  logic       inRst,
    input  logic       iSCL,
    input  logic       iSDA,
    output logic       onSCLOE,
    output logic       onSDAOE,
    input  logic       iStart,
    input  logic       iRnW,
    input  logic [6:0] ivTargetAddr,
    input  logic [7:0] ivRegAddr,
    input  logic [7:0] ivWrData,
    output logic [7:0] ovRdData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oNack
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TXBIT,
        ST_RXACK,
        ST_RESTART,
        ST_RXBIT,
        ST_TXNACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [9:0] LP_QLAST = 10'(QTR_DIV - 1);

    logic       r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
    state_t     r_state, w_state_nxt;
    logic [9:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_qtr, w_qtr_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic [1:0] r_byte, w_byte_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_rx, w_rx_nxt;
    logic [7:0] r_rd_data, w_rd_data_nxt;
    logic       r_ack, w_ack_nxt;
    logic       r_nack, w_nack_nxt;
    logic       r_rnw;
    logic [6:0] r_addr;
    logic [7:0] r_reg, r_wdata;
    logic       r_scl_oe, r_sda_oe, r_busy, r_done;
    logic       w_accept, w_stretch_q, w_cnt_last, w_qend, w_slot_end, w_sample;
    logic [1:0] w_pins;

    // {SCL release, SDA release} for a given state/quarter; b is the data bit for TXBIT.
    function automatic logic [1:0] f_pins(input state_t s, input logic [1:0] q, input logic b);
        logic [1:0] v;
        v = 2'b11;
        case (s)
            ST_START:                      v = {1'b1, q < 2'd2};
            ST_TXBIT:                      v = {q[1], b};
            ST_RXACK, ST_RXBIT, ST_TXNACK: v = {q[1], 1'b1};
            ST_RESTART:                    v = {q != 2'd0, q < 2'd2};
            ST_STOP:                       v = {q != 2'd0, q[1]};
            default:                       v = 2'b11;
        endcase
        return v;
    endfunction

    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_scl_meta <= iSCL;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= iSDA;
            r_sda_sync <= r_sda_meta;
        end
    end

    always_comb begin
        w_accept    = (r_state == ST_IDLE) && iStart;
        w_stretch_q = ((r_state inside {ST_TXBIT, ST_RXACK, ST_RXBIT, ST_TXNACK}) && (r_qtr == 2'd2))
                   || ((r_state inside {ST_RESTART, ST_STOP}) && (r_qtr == 2'd1));
        w_cnt_last  = (r_cnt == LP_QLAST);
        // A released-SCL quarter may only end once the line is actually seen high.
        w_qend      = w_cnt_last && !(w_stretch_q && !r_scl_sync)
                   && (r_state != ST_IDLE) && (r_state != ST_DONE);
        w_slot_end  = w_qend && (r_qtr == 2'd3);
        w_sample    = w_qend && (r_qtr == 2'd2);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_qtr_nxt     = r_qtr;
        w_bit_nxt     = r_bit;
        w_byte_nxt    = r_byte;
        w_shift_nxt   = r_shift;
        w_rx_nxt      = r_rx;
        w_rd_data_nxt = r_rd_data;
        w_ack_nxt     = r_ack;
        w_nack_nxt    = r_nack;

        if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            w_cnt_nxt = '0;
            w_qtr_nxt = '0;
        end else if (w_qend) begin
            w_cnt_nxt = '0;
            w_qtr_nxt = r_qtr + 2'd1;
        end else if (!w_cnt_last) begin
            w_cnt_nxt = r_cnt + 10'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nack_nxt  = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_slot_end) begin
                    w_state_nxt = ST_TXBIT;
                    w_shift_nxt = {r_addr, 1'b0};
                    w_bit_nxt   = '0;
                    w_byte_nxt  = 2'd0;
                end
            end
            ST_TXBIT: begin
                if (w_slot_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_RXACK;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                    end
                end
            end
            ST_RXACK: begin
                if (w_sample) w_ack_nxt = r_sda_sync;
                if (w_slot_end) begin
                    if (r_ack) begin
                        w_nack_nxt  = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        case (r_byte)
                            2'd0: begin
                                w_state_nxt = ST_TXBIT;
                                w_shift_nxt = r_reg;
                                w_byte_nxt  = 2'd1;
                            end
                            2'd1: begin
                                if (r_rnw) begin
                                    w_state_nxt = ST_RESTART;
                                end else begin
                                    w_state_nxt = ST_TXBIT;
                                    w_shift_nxt = r_wdata;
                                    w_byte_nxt  = 2'd2;
                                end
                            end
                            default: w_state_nxt = r_rnw ? ST_RXBIT : ST_STOP;
                        endcase
                    end
                end
            end
            ST_RESTART: begin
                if (w_slot_end) begin
                    w_state_nxt = ST_TXBIT;
                    w_shift_nxt = {r_addr, 1'b1};
                    w_bit_nxt   = '0;
                    w_byte_nxt  = 2'd2;
                end
            end
            ST_RXBIT: begin
                if (w_sample) w_rx_nxt = {r_rx[6:0], r_sda_sync};
                if (w_slot_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_TXNACK;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            ST_TXNACK: begin
                if (w_slot_end) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_slot_end) begin
                    w_state_nxt = ST_DONE;
                    if (r_rnw && !r_nack) w_rd_data_nxt = r_rx;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // Pins are registered from next-state values: same timing as a decode, no glitches.
        w_pins = f_pins(w_state_nxt, w_qtr_nxt, w_shift_nxt[7]);
    end

    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_qtr     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_ack     <= 1'b0;
            r_nack    <= 1'b0;
            r_scl_oe  <= 1'b1;
            r_sda_oe  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_qtr     <= w_qtr_nxt;
            r_bit     <= w_bit_nxt;
            r_byte    <= w_byte_nxt;
            r_shift   <= w_shift_nxt;
            r_rx      <= w_rx_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_ack     <= w_ack_nxt;
            r_nack    <= w_nack_nxt;
            r_scl_oe  <= w_pins[1];
            r_sda_oe  <= w_pins[0];
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_reg   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rnw   <= iRnW;
            r_addr  <= ivTargetAddr;
            r_reg   <= ivRegAddr;
            r_wdata <= ivWrData;
        end
    end

    assign onSCLOE  = r_scl_oe;
    assign onSDAOE  = r_sda_oe;
    assign ovRdData = r_rd_data;
    assign oBusy    = r_busy;
    assign oDone    = r_done;
    assign oNack    = r_nack;

endmodule

// File: tb/tb_iic_reg_master.sv
// Bench for iic_reg_master: an open-drain bus with a behavioural register target,
// a transaction-level expectation model and a per-cycle compare of the handshake outputs.
module tb_iic_reg_master;

    localparam int unsigned Q    = 4;
    localparam int          HOLD = Q + 98;   // SCL held HOLD cycles after release; seen 2 flops later -> +100 cycles
    localparam logic [6:0]  TGT  = 7'h50;
    localparam int          TOK_S = 1024;
    localparam int          TOK_P = 1025;
    localparam int          M_IDLE = 0, M_ADDR = 1, M_REG = 2, M_DATA = 3, M_TX = 4;

    logic       iClk = 1'b0;
    logic       inRst;
    logic       iStart = 1'b0, iRnW = 1'b0;
    logic [6:0] ivTargetAddr = '0;
    logic [7:0] ivRegAddr = '0, ivWrData = '0;
    logic       onSCLOE, onSDAOE, oBusy, oDone, oNack;
    logic [7:0] ovRdData;
    logic       tgt_scl_hold = 1'b0, tgt_sda_low = 1'b0;
    logic       scl_line, sda_line;

    assign scl_line = onSCLOE & ~tgt_scl_hold;
    assign sda_line = onSDAOE & ~tgt_sda_low;

    iic_reg_master #(.QTR_DIV(Q)) dut (
        .iClk(iClk), .inRst(inRst), .iSCL(scl_line), .iSDA(sda_line),
        .onSCLOE(onSCLOE), .onSDAOE(onSDAOE), .iStart(iStart), .iRnW(iRnW),
        .ivTargetAddr(ivTargetAddr), .ivRegAddr(ivRegAddr), .ivWrData(ivWrData),
        .ovRdData(ovRdData), .oBusy(oBusy), .oDone(oDone), .oNack(oNack)
    );

    always #5 iClk = ~iClk;

    int errors = 0, checks = 0, cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level expectations
    int         exp_start = -10, exp_done = -10, done_seen = -1;
    logic [7:0] exp_rd = 8'h00;
    logic       exp_nack = 1'b0;
    logic [7:0] exp_mem [256];
    int         exp_q [$];

    logic busy_e;
    always @(negedge iClk) begin
        if (inRst === 1'b1) begin
            busy_e = (cyc > exp_start) && (cyc <= exp_done);
            check("oBusy", oBusy, busy_e);
            check("oDone", oDone, cyc == exp_done);
            if (!busy_e) check("idle_pins", {onSCLOE, onSDAOE}, 2'b11);
            if (oDone === 1'b1) done_seen = cyc;
        end
    end

    // Behavioural register target: ACKs TGT, registers F0..FF do not exist.
    logic [7:0] tgt_mem [256];
    int         bus_q [$];
    int         t_bitcnt = 0, t_mode = 0, t_rel = 0;
    logic [7:0] t_sh = '0, t_last = '0, t_txb = '0, t_regptr = '0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_sdaoe = 1'b1, cur_scl, cur_sda;
    logic       stretch_en = 1'b0;

    task automatic tgt_reset();
        t_mode = M_IDLE; t_bitcnt = 0;
        tgt_sda_low = 1'b0; tgt_scl_hold = 1'b0; stretch_en = 1'b0;
    endtask

    always @(negedge iClk) begin
        cur_scl = scl_line;
        cur_sda = sda_line;
        if (cur_scl && prev_scl && (cur_sda != prev_sda)) begin
            bus_q.push_back(cur_sda ? TOK_P : TOK_S);
            t_mode   = cur_sda ? M_IDLE : M_ADDR;
            t_bitcnt = 0;
        end else if (cur_scl && !prev_scl) begin
            if (t_bitcnt < 8) begin
                t_sh = {t_sh[6:0], cur_sda};
                t_bitcnt++;
            end else if (t_bitcnt == 8) begin
                bus_q.push_back((cur_sda ? 256 : 0) + int'(t_last));
                if (t_mode == M_TX && cur_sda) t_mode = M_IDLE;
                t_bitcnt = 9;
            end
        end else if (!cur_scl && prev_scl) begin
            if (t_bitcnt == 9) begin
                tgt_sda_low = 1'b0;
                t_bitcnt = 0;
                if (t_mode == M_TX) tgt_sda_low = ~t_txb[7];
            end else if (t_bitcnt == 8) begin
                t_last = t_sh;
                tgt_sda_low = 1'b0;
                case (t_mode)
                    M_ADDR: begin
                        if (t_sh[7:1] == TGT) begin
                            tgt_sda_low = 1'b1;
                            if (t_sh[0]) begin
                                t_mode = M_TX;
                                t_txb  = tgt_mem[t_regptr];
                            end else begin
                                t_mode = M_REG;
                            end
                        end else begin
                            t_mode = M_IDLE;
                        end
                    end
                    M_REG: begin
                        if (t_sh < 8'hF0) begin
                            t_regptr = t_sh;
                            tgt_sda_low = 1'b1;
                            t_mode = M_DATA;
                        end else begin
                            t_mode = M_IDLE;
                        end
                    end
                    M_DATA: begin
                        tgt_mem[t_regptr] = t_sh;
                        tgt_sda_low = 1'b1;
                        t_mode = M_IDLE;
                    end
                    default: ;
                endcase
            end else if (t_mode == M_TX && t_bitcnt > 0) begin
                tgt_sda_low = ~t_txb[7 - t_bitcnt];
            end
            if (stretch_en && (t_mode == M_DATA || t_mode == M_TX) && t_bitcnt == 3) begin
                tgt_scl_hold = 1'b1;
                t_rel = 0;
                stretch_en = 1'b0;
            end
        end
        if (tgt_scl_hold && onSCLOE) begin
            check("sda_while_stretched", onSDAOE, prev_sdaoe);
            t_rel++;
            if (t_rel >= HOLD) tgt_scl_hold = 1'b0;
        end
        prev_scl   = cur_scl;
        prev_sda   = cur_sda;
        prev_sdaoe = onSDAOE;
    end

    task automatic run_txn(input logic rnw, input logic [6:0] addr, input logic [7:0] rg,
                           input logic [7:0] wd, input logic stretch, input logic mid, output int lat);
        int n, extra;
        logic hit;
        @(posedge iClk); #2;
        bus_q.delete();
        exp_q.delete();
        stretch_en = stretch;
        hit = (addr == TGT);
        exp_q.push_back(TOK_S);
        exp_q.push_back((hit ? 0 : 256) + int'(addr) * 2);
        if (!hit) begin
            n = 44;
        end else begin
            exp_q.push_back(((rg >= 8'hF0) ? 256 : 0) + int'(rg));
            if (rg >= 8'hF0) begin
                n = 44 + 36;
            end else if (!rnw) begin
                exp_q.push_back(int'(wd));
                n = 116;
                exp_mem[rg] = wd;
            end else begin
                exp_q.push_back(TOK_S);
                exp_q.push_back(int'(addr) * 2 + 1);
                exp_q.push_back(256 + int'(exp_mem[rg]));
                n = 156;
                exp_rd = exp_mem[rg];
            end
        end
        exp_q.push_back(TOK_P);
        exp_nack  = !hit || (rg >= 8'hF0);
        extra     = (stretch && n >= 116) ? (HOLD + 2 - int'(Q)) : 0;
        exp_start = cyc;
        exp_done  = cyc + 1 + n * int'(Q) + extra;
        done_seen = -1;
        iRnW = rnw; ivTargetAddr = addr; ivRegAddr = rg; ivWrData = wd; iStart = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        ivTargetAddr = 7'($urandom); ivRegAddr = 8'($urandom); ivWrData = 8'($urandom);
        if (mid) begin
            repeat ($urandom_range(10, n * int'(Q) - 10)) @(posedge iClk);
            #2;
            iRnW = ~rnw; ivTargetAddr = addr ^ 7'h15; ivRegAddr = ~rg; ivWrData = ~wd; iStart = 1'b1;
            @(posedge iClk); #2;
            iStart = 1'b0;
        end
        while (cyc < exp_done + 1) @(posedge iClk);
        #2;
        lat = done_seen - exp_start;
        check("oNack", oNack, exp_nack);
        check("ovRdData", ovRdData, exp_rd);
        check("bus_len", bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
            check("bus_token", bus_q[i], exp_q[i]);
        stretch_en = 1'b0;
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tgt_mem[i] = 8'($urandom);
            exp_mem[i] = tgt_mem[i];
        end
        tgt_mem[8'h12] = 8'hA5;
        exp_mem[8'h12] = 8'hA5;
        inRst = 1'b1;
        #1 inRst = 1'b0;
        repeat (3) @(posedge iClk);
        #2;
        check("rst_scl", onSCLOE, 1'b1);
        check("rst_sda", onSDAOE, 1'b1);
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oDone, 1'b0);
        check("rst_nack", oNack, 1'b0);
        check("rst_rd", ovRdData, 8'h00);
        inRst = 1'b1;

        run_txn(1'b0, 7'h50, 8'h30, 8'h5A, 1'b0, 1'b0, lat);
        check("write_latency", lat, 465);
        check("write_landed", tgt_mem[8'h30], 8'h5A);
        check("write_nack", oNack, 1'b0);

        run_txn(1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 1'b0, lat);
        check("read_latency", lat, 625);
        check("read_data", ovRdData, 8'hA5);

        run_txn(1'b0, 7'h21, 8'h40, 8'h11, 1'b0, 1'b0, lat);
        check("noack_latency", lat, 177);
        check("noack_nack", oNack, 1'b1);
        check("noack_rd_kept", ovRdData, 8'hA5);

        run_txn(1'b0, 7'h50, 8'h31, 8'h3C, 1'b1, 1'b0, lat);
        check("stretch_latency", lat, 565);

        run_txn(1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 1'b1, lat);
        check("mid_start_latency", lat, 625);

        run_txn(1'b0, 7'h50, 8'hF4, 8'h77, 1'b0, 1'b0, lat);
        check("regnack_latency", lat, 321);

        // Reset during the register byte
        @(posedge iClk); #2;
        iRnW = 1'b0; ivTargetAddr = 7'h50; ivRegAddr = 8'h45; ivWrData = 8'h99; iStart = 1'b1;
        exp_start = cyc;
        exp_done  = cyc + 1 + 116 * int'(Q);
        @(posedge iClk); #2;
        iStart = 1'b0;
        while (cyc < exp_start + 1 + 50 * int'(Q)) @(posedge iClk);
        #2;
        inRst = 1'b0;
        exp_start = -10;
        exp_done  = -10;
        exp_rd    = 8'h00;
        tgt_reset();
        #1;
        check("arst_scl", onSCLOE, 1'b1);
        check("arst_sda", onSDAOE, 1'b1);
        check("arst_busy", oBusy, 1'b0);
        check("arst_rd", ovRdData, 8'h00);
        repeat (3) @(posedge iClk);
        #2;
        tgt_reset();
        bus_q.delete();
        inRst = 1'b1;
        run_txn(1'b0, 7'h50, 8'h45, 8'h99, 1'b0, 1'b0, lat);
        check("post_reset_latency", lat, 465);

        for (int t = 0; t < 20; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : TGT;
            run_txn(1'($urandom), a, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iic_reg_master.md
# iic_reg_master

SMBus/I2C master that performs single-register byte write and byte read transactions against a remote target, the initiator counterpart to the CPLD's IIC register slave. It sits between internal control logic (sequencers, BMC-bridging logic) and an open-drain SMBus segment. It drives SCL and SDA through active-low tri-state enables and supports target clock stretching. It is single-master only, with no arbitration.

## Interface
Parameters:
- QTR_DIV, 63: iClk cycles per SCL quarter-period. Legal range is 4..1023; the SCL period is 4*QTR_DIV cycles.

Ports:
- iClk  in  1  system clock; only clock.
- inRst  in  1  asynchronous, active-low reset.
- iSCL  in  1  SCL pin level, asynchronous; double-flop synchronized internally.
- iSDA  in  1  SDA pin level, asynchronous; double-flop synchronized internally.
- onSCLOE  out  1  0 pulls SCL low, 1 releases it.
- onSDAOE  out  1  0 pulls SDA low, 1 releases it.
- iStart  in  1  one-cycle request pulse; honored only when oBusy=0.
- iRnW  in  1  1 = register read, 0 = register write.
- ivTargetAddr  in  7  7-bit target address.
- ivRegAddr  in  8  register index.
- ivWrData  in  8  write data byte.
- ovRdData  out  8  read data byte; valid when oDone=1 and oNack=0.
- oBusy  out  1  transaction in progress.
- oDone  out  1  one-cycle completion pulse.
- oNack  out  1  last transaction got a NACK; held until the next accepted iStart.

## Operation
- Reset values: onSCLOE=1, onSDAOE=1, oBusy=0, oDone=0, oNack=0, ovRdData=8'h00, FSM=IDLE.
- Reset takes effect immediately, including mid-transaction. Both lines are released and the transaction is abandoned; the block does not generate a STOP.
- On iStart in IDLE:
  - latch iRnW, the address, the register index and the data;
  - clear oNack;
  - set oBusy;
  - restart the quarter counter.
- iStart while oBusy=1 is ignored. Latched fields never change mid-transaction.
- Write sequence: S, {addr,0}, A, reg, A, data, A, P.
- Read sequence: S, {addr,0}, A, reg, A, Sr, {addr,1}, A, data, NACK (master), P.
- Bytes are sent MSB first.
- FSM states: IDLE, START, TXBIT, RXACK, RESTART, RXBIT, TXNACK, STOP, DONE.
- Each bit slot is four quarters:
  - q0: SCL low; SDA updated at q0 entry.
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL high. SDA is sampled from the synchronized input at q3 entry.
- START: SCL and SDA released for q0–q1, SDA low for q2–q3, then SCL low at the next slot's q0.
- RESTART: q0 SCL low with SDA released; q1 SCL released; q2–q3 SCL high with SDA pulled low.
- STOP: q0 SCL low with SDA low; q1 SCL released with SDA low; q2–q3 SDA released.
- RXACK: SDA released.
  - Sampled 0 → continue.
  - Sampled 1 → set oNack and branch to STOP. No further bytes are sent.
- RXBIT: SDA released for 8 slots, bits shifted into a holding register. ovRdData updates only at DONE, and only for a successful read.
- TXNACK: SDA released for one slot.
- DONE: one cycle. Pulse oDone, clear oBusy, return to IDLE.
- Clock stretching: at the last cycle of any quarter with SCL released, if synchronized SCL is still 0, the counter holds until it reads 1. This applies to bit-slot q2, RESTART q1 and STOP q1.
- SDA is never changed while SCL is driven high, except in the START, RESTART and STOP conditions.

## Timing
- Quarter counter: 10-bit, counts 0..QTR_DIV-1, wraps to 0 and advances the quarter.
- Accepting iStart (cycle 0 is the cycle iStart is sampled) asserts oBusy in cycle 1.
- Without stretching, oDone occurs at cycle 1 + N*QTR_DIV:
  - N=116 for a write (4 start + 27 slots×4 + 4 stop);
  - N=156 for a read (4 + 72 + 4 restart + 72 + 4).
- NACK on the address byte: N=44 (4 + 36 + 4). NACK on the register byte: N=80.
- A stall of k cycles beyond the 2-cycle synchronizer delay adds exactly k cycles to latency. QTR_DIV≥4 absorbs the synchronizer delay with no penalty.
- A new iStart is accepted in the cycle after oDone.

## Test plan
- Write, QTR_DIV=4, addr 7'h50, reg 8'h30, data 8'h5A, model ACKs → bus shows bytes A0,30,5A with STOP; oDone at cycle 465; oNack=0.
- Read, addr 7'h50, reg 8'h12, model returns 8'hA5 → bytes A0,12,Sr,A1; master NACKs the data byte; ovRdData=8'hA5; oDone at cycle 625.
- No target present (SDA stays high) → oNack=1, oDone at cycle 177, STOP generated, ovRdData unchanged.
- Target stretches SCL 100 cycles during data-bit q2 → no SDA change while SCL is low-held; oDone 100 cycles later than nominal; data correct.
- iStart pulsed again mid-transaction with different fields → ignored; bus traffic and latency match the first request only.
- inRst asserted during the reg byte → onSCLOE=onSDAOE=1 and oBusy=0 immediately; after release, a new write completes normally.
